// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: one-outstanding memory port shared by IF and LS.
// Optional RISCV_ARB_TIMEOUT_EN: WAIT timeout with error response.
module riscv_mem_arbiter #(
    parameter int WORD_SIZE      = 32,
    parameter int MAX_LS_STREAK  = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_if_req,
    input  logic [WORD_SIZE-1:0] i_if_addr,
    output logic                 o_if_gnt,
    output logic                 o_if_rvalid,
    output logic [WORD_SIZE-1:0] o_if_rdata,
    input  logic                 i_ls_req,
    input  logic                 i_ls_we,
    input  logic [WORD_SIZE-1:0] i_ls_addr,
    input  logic [WORD_SIZE-1:0] i_ls_wdata,
    input  logic [3:0]           i_ls_be,
    output logic                 o_ls_gnt,
    output logic                 o_ls_rvalid,
    output logic [WORD_SIZE-1:0] o_ls_rdata,
    output logic                 o_mem_req,
    output logic                 o_mem_we,
    output logic [WORD_SIZE-1:0] o_mem_addr,
    output logic [WORD_SIZE-1:0] o_mem_wdata,
    output logic [3:0]           o_mem_be,
    input  logic                 i_mem_gnt,
    input  logic                 i_mem_rvalid,
    input  logic [WORD_SIZE-1:0] i_mem_rdata,
    output logic                 o_busy,
    output logic                 o_err
);

    localparam int SW = $clog2(MAX_LS_STREAK + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LS_STREAK);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t               state;
    state_t               state_next;
    logic                 owner_ls;
    logic [SW-1:0]        ls_streak;
    logic                 grant_if;
    logic                 grant_ls;
    logic                 resp;
    logic                 timeout_hit;
    logic [WORD_SIZE-1:0] resp_data;

    // Next-state, grant arbitration and response detection.
    always_comb begin
        state_next = state;
        grant_if   = 1'b0;
        grant_ls   = 1'b0;
        resp       = 1'b0;
        unique case (state)
            IDLE: begin
                if (!i_reset) begin
                    if (i_ls_req &&
                        (!i_if_req || ls_streak != STREAK_MAX)) begin
                        grant_ls = 1'b1;
                    end else if (i_if_req) begin
                        grant_if = 1'b1;
                    end
                    if (grant_ls || grant_if) begin
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (i_mem_gnt) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (!i_reset && (i_mem_rvalid || timeout_hit)) begin
                    resp       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign o_if_gnt    = grant_if;
    assign o_ls_gnt    = grant_ls;
    assign o_if_rvalid = resp && !owner_ls;
    assign o_ls_rvalid = resp && owner_ls;
    assign resp_data   = timeout_hit ? '0 : i_mem_rdata;
    assign o_if_rdata  = o_if_rvalid ? resp_data : '0;
    assign o_ls_rdata  = o_ls_rvalid ? resp_data : '0;
    assign o_busy      = (state != IDLE);

    // State, owner, streak counter and registered memory request.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state       <= IDLE;
            owner_ls    <= 1'b0;
            ls_streak   <= '0;
            o_mem_req   <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_mem_be    <= 4'h0;
        end else begin
            state <= state_next;
            if (grant_ls) begin
                owner_ls    <= 1'b1;
                o_mem_req   <= 1'b1;
                o_mem_we    <= i_ls_we;
                o_mem_addr  <= i_ls_addr;
                o_mem_wdata <= i_ls_wdata;
                o_mem_be    <= i_ls_be;
                if (!i_if_req) begin
                    ls_streak <= '0;
                end else if (ls_streak != STREAK_MAX) begin
                    ls_streak <= ls_streak + 1'b1;
                end
            end else if (grant_if) begin
                owner_ls    <= 1'b0;
                o_mem_req   <= 1'b1;
                o_mem_we    <= 1'b0;
                o_mem_addr  <= i_if_addr;
                o_mem_wdata <= '0;
                o_mem_be    <= 4'hF;
                ls_streak   <= '0;
            end else if (state == ISSUE && i_mem_gnt) begin
                o_mem_req <= 1'b0;
            end
        end
    end

`ifdef RISCV_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

    logic [TW-1:0] tmo_cnt;

    assign timeout_hit = (state == WAIT) && (tmo_cnt == TMO_MAX);

    // WAIT-cycle counter; o_err lines up with the forced response.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tmo_cnt <= '0;
            o_err   <= 1'b0;
        end else begin
            o_err <= (state == WAIT) && !i_mem_rvalid &&
                     (tmo_cnt == TMO_MAX - 1'b1);
            if (state == ISSUE) begin
                tmo_cnt <= '0;
            end else if (state == WAIT && !i_mem_rvalid && !timeout_hit) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
        end
    end
`else
    // Timeout disabled: never fires, whatever TIMEOUT_CYCLES says.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
    assign o_err       = 1'b0;
`endif

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_riscv_mem_arbiter;

    localparam int W    = 32;
    localparam int MAXS = 4;
    localparam int TMO  = 16;
`ifdef RISCV_ARB_TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         if_req;
    logic [W-1:0] if_addr;
    logic         if_gnt, if_rvalid;
    logic [W-1:0] if_rdata;
    logic         ls_req, ls_we;
    logic [W-1:0] ls_addr, ls_wdata;
    logic [3:0]   ls_be;
    logic         ls_gnt, ls_rvalid;
    logic [W-1:0] ls_rdata;
    logic         mem_req, mem_we;
    logic [W-1:0] mem_addr, mem_wdata;
    logic [3:0]   mem_be;
    logic         mem_gnt, mem_rvalid;
    logic [W-1:0] mem_rdata;
    logic         busy, err;

    always #5 clk = ~clk;

    riscv_mem_arbiter #(
        .WORD_SIZE(W),
        .MAX_LS_STREAK(MAXS),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_if_req(if_req),
        .i_if_addr(if_addr),
        .o_if_gnt(if_gnt),
        .o_if_rvalid(if_rvalid),
        .o_if_rdata(if_rdata),
        .i_ls_req(ls_req),
        .i_ls_we(ls_we),
        .i_ls_addr(ls_addr),
        .i_ls_wdata(ls_wdata),
        .i_ls_be(ls_be),
        .o_ls_gnt(ls_gnt),
        .o_ls_rvalid(ls_rvalid),
        .o_ls_rdata(ls_rdata),
        .o_mem_req(mem_req),
        .o_mem_we(mem_we),
        .o_mem_addr(mem_addr),
        .o_mem_wdata(mem_wdata),
        .o_mem_be(mem_be),
        .i_mem_gnt(mem_gnt),
        .i_mem_rvalid(mem_rvalid),
        .i_mem_rdata(mem_rdata),
        .o_busy(busy),
        .o_err(err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Transaction-level model: one outstanding transaction record.
    bit         chk_on = 1'b0;
    bit         m_busy = 1'b0;
    bit         m_acc = 1'b0;
    bit         m_own_ls = 1'b0;
    int         m_streak = 0;
    int         m_cnt = 0;
    logic       m_req = 1'b0;
    logic       m_we = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [3:0] m_be = '0;
    bit         e_if_gnt = 1'b0;
    bit         e_ls_gnt = 1'b0;

    always @(negedge clk) begin
        bit gi, gl, rsp, tmo;
        logic [31:0] rd;
        if (chk_on) begin
            gi  = 1'b0;
            gl  = 1'b0;
            rsp = 1'b0;
            tmo = TMO_ON && m_busy && m_acc && (m_cnt == TMO);
            if (!rst && !m_busy) begin
                if (ls_req && (!if_req || m_streak < MAXS)) gl = 1'b1;
                else if (if_req) gi = 1'b1;
            end
            if (!rst && m_busy && m_acc && (mem_rvalid || tmo)) rsp = 1'b1;
            rd = tmo ? 32'h0 : mem_rdata;
            chk("if_gnt", {31'h0, if_gnt}, {31'h0, gi});
            chk("ls_gnt", {31'h0, ls_gnt}, {31'h0, gl});
            chk("if_rvalid", {31'h0, if_rvalid}, {31'h0, rsp && !m_own_ls});
            chk("ls_rvalid", {31'h0, ls_rvalid}, {31'h0, rsp && m_own_ls});
            chk("if_rdata", if_rdata, (rsp && !m_own_ls) ? rd : 32'h0);
            chk("ls_rdata", ls_rdata, (rsp && m_own_ls) ? rd : 32'h0);
            chk("mem_req", {31'h0, mem_req}, {31'h0, m_req});
            if (m_req) begin
                chk("mem_we", {31'h0, mem_we}, {31'h0, m_we});
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_be", {28'h0, mem_be}, {28'h0, m_be});
                if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
            end
            chk("busy", {31'h0, busy}, {31'h0, m_busy});
            chk("err", {31'h0, err}, {31'h0, tmo});
            e_if_gnt = gi;
            e_ls_gnt = gl;
            if (rst) begin
                m_busy = 1'b0; m_acc = 1'b0; m_own_ls = 1'b0;
                m_streak = 0; m_cnt = 0;
                m_req = 1'b0; m_we = 1'b0; m_addr = '0;
                m_wdata = '0; m_be = '0;
            end else if (gl || gi) begin
                m_busy = 1'b1; m_acc = 1'b0; m_own_ls = gl; m_req = 1'b1;
                m_we   = gl ? ls_we : 1'b0;
                m_addr = gl ? ls_addr : if_addr;
                m_wdata = ls_wdata;
                m_be   = gl ? ls_be : 4'hF;
                if (gl && if_req) m_streak = (m_streak < MAXS) ? m_streak + 1 : MAXS;
                else m_streak = 0;
            end else if (m_busy && !m_acc) begin
                if (mem_gnt) begin
                    m_acc = 1'b1; m_req = 1'b0; m_cnt = 0;
                end
            end else if (m_busy && m_acc) begin
                if (rsp) m_busy = 1'b0;
                else m_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int got;
        int exp_if[6] = '{0, 0, 0, 0, 1, 0};
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_be = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        step();
        chk_on = 1'b1;
        step();
        rst = 1'b0;
        #2;
        chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_be", {28'h0, mem_be}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);

        // Single IF read.
        step(); if_req = 1'b1; if_addr = 32'h100;
        #2 chk("rd_if_gnt", {31'h0, if_gnt}, 32'h1);
        step(); if_req = 1'b0; mem_gnt = 1'b1;
        #2 chk("rd_mem_req", {31'h0, mem_req}, 32'h1);
        chk("rd_mem_addr", mem_addr, 32'h100);
        chk("rd_mem_be", {28'h0, mem_be}, 32'hF);
        chk("rd_mem_we", {31'h0, mem_we}, 32'h0);
        step(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
        #2 chk("rd_if_rvalid", {31'h0, if_rvalid}, 32'h1);
        chk("rd_if_rdata", if_rdata, 32'hDEADBEEF);
        chk("rd_ls_rdata", ls_rdata, 32'h0);
        step(); mem_rvalid = 1'b0;
        #2 chk("rd_idle", {31'h0, busy}, 32'h0);

        // LS store with a 3-cycle gnt stall.
        step(); ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h200;
        ls_wdata = 32'h12345678; ls_be = 4'h3;
        #2 chk("st_ls_gnt", {31'h0, ls_gnt}, 32'h1);
        for (int k = 0; k < 3; k++) begin
            step(); ls_req = 1'b0; ls_addr = $urandom; ls_wdata = $urandom;
            #2 chk("st_hold_req", {31'h0, mem_req}, 32'h1);
            chk("st_hold_addr", mem_addr, 32'h200);
            chk("st_hold_wdata", mem_wdata, 32'h12345678);
            chk("st_hold_be", {28'h0, mem_be}, 32'h3);
            chk("st_hold_we", {31'h0, mem_we}, 32'h1);
        end
        step(); mem_gnt = 1'b1;
        step(); mem_gnt = 1'b0;
        #2 chk("st_req_drop", {31'h0, mem_req}, 32'h0);
        step(); mem_rvalid = 1'b1; mem_rdata = 32'hCAFE0000;
        #2 chk("st_ls_rvalid", {31'h0, ls_rvalid}, 32'h1);
        chk("st_if_rvalid", {31'h0, if_rvalid}, 32'h0);
        step(); mem_rvalid = 1'b0; ls_we = 1'b0;

        // Simultaneous requests: LS first, IF waits.
        step(); if_req = 1'b1; if_addr = 32'h300;
        ls_req = 1'b1; ls_addr = 32'h400; ls_be = 4'hF;
        #2 chk("sim_ls_gnt", {31'h0, ls_gnt}, 32'h1);
        chk("sim_if_gnt0", {31'h0, if_gnt}, 32'h0);
        step(); ls_req = 1'b0; mem_gnt = 1'b1;
        #2 chk("sim_if_gnt1", {31'h0, if_gnt}, 32'h0);
        step(); mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h55;
        #2 chk("sim_if_gnt2", {31'h0, if_gnt}, 32'h0);
        step(); mem_rvalid = 1'b0;
        #2 chk("sim_if_gnt3", {31'h0, if_gnt}, 32'h1);
        step(); if_req = 1'b0; mem_gnt = 1'b1;
        step(); mem_gnt = 1'b0; mem_rvalid = 1'b1;
        step(); mem_rvalid = 1'b0;

        // Starvation limit: LS x4, then IF, then LS.
        step(); if_req = 1'b1; ls_req = 1'b1; mem_gnt = 1'b1; mem_rvalid = 1'b1;
        got = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            if (c > 0) step();
            #2;
            if (if_gnt || ls_gnt) begin
                chk($sformatf("starve_%0d", got), {31'h0, if_gnt}, exp_if[got]);
                got++;
            end
        end
        chk("starve_count", got, 6);
        step(); if_req = 1'b0; ls_req = 1'b0;
        step(); step();
        mem_gnt = 1'b0; mem_rvalid = 1'b0;

        // Reset in WAIT abandons the transaction.
        step(); if_req = 1'b1; if_addr = 32'h500;
        step(); if_req = 1'b0; mem_gnt = 1'b1;
        step(); mem_gnt = 1'b0;
        step(); rst = 1'b1;
        step(); ls_req = 1'b1; mem_rvalid = 1'b1;
        #2 chk("rst_no_gnt", {31'h0, ls_gnt}, 32'h0);
        chk("rst_no_rvalid", {31'h0, if_rvalid}, 32'h0);
        step(); rst = 1'b0; ls_req = 1'b0;
        #2 chk("rst2_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst2_busy", {31'h0, busy}, 32'h0);
        chk("rst2_late_rvalid", {31'h0, if_rvalid}, 32'h0);
        step(); mem_rvalid = 1'b0;

`ifdef RISCV_ARB_TIMEOUT_EN
        // Memory never answers: forced response after TMO cycles.
        step(); if_req = 1'b1; if_addr = 32'h600;
        step(); if_req = 1'b0; mem_gnt = 1'b1;
        step(); mem_gnt = 1'b0;
        got = -1;
        for (int k = 0; k < 40; k++) begin
            #2;
            if (if_rvalid) begin
                got = k;
                chk("tmo_rdata", if_rdata, 32'h0);
                chk("tmo_err", {31'h0, err}, 32'h1);
                break;
            end
            step();
        end
        chk("tmo_cycle", got, TMO);
        step(); mem_rvalid = 1'b1; mem_rdata = 32'h77;
        #2 chk("tmo_late", {31'h0, if_rvalid}, 32'h0);
        chk("tmo_idle", {31'h0, busy}, 32'h0);
        step(); mem_rvalid = 1'b0;
`endif

        // Randomized traffic, checked by the model every cycle.
        for (int c = 0; c < 3000; c++) begin
            step();
            rst = ($urandom_range(0, 299) == 0);
            if (if_req && e_if_gnt) begin
                if_req = 1'($urandom_range(0, 1)); if_addr = $urandom;
            end else if (if_req) begin
                if ($urandom_range(0, 15) == 0) if_req = 1'b0;
            end else begin
                if_req = 1'($urandom_range(0, 1)); if_addr = $urandom;
            end
            if (ls_req && !e_ls_gnt) begin
                if ($urandom_range(0, 15) == 0) ls_req = 1'b0;
            end else begin
                ls_req = 1'($urandom_range(0, 1));
                ls_we = 1'($urandom_range(0, 1));
                ls_addr = $urandom; ls_wdata = $urandom; ls_be = 4'($urandom);
            end
            mem_gnt = ($urandom_range(0, 2) != 0);
            mem_rvalid = ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom;
        end
        rst = 1'b0; if_req = 1'b0; ls_req = 1'b0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0;
        step(); step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
